music_box_sequencer: RTL and testbench

Plays a stored song on the square-wave note bank. It reads note events from an external synchronous song ROM and drives the 24 note-enable lines of the bank for each event's duration, with an articulation gap between events. Live keyboard keys are OR-merged in, which lets the piano and music-box modes share the bank. It sits between the switch/key decode logic and the square-wave control block.

---
 rtl/music_pkg.sv | 47 ++++
 rtl/tick_prescaler.sv | 30 +++
 rtl/music_box_sequencer.sv | 136 +++++++++++++
 tb/tb_music_box_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music-box sequencer: note-bank layout, song-entry
// format and sequencer states.
package music_pkg;

    localparam int NOTES = 24;
    localparam int DUR_W = 8;

    // Note-enable bit positions, lowest octave first.
    localparam int N_1C  = 0;
    localparam int N_1D  = 1;
    localparam int N_1E  = 2;
    localparam int N_1F  = 3;
    localparam int N_1G  = 4;
    localparam int N_1A  = 5;
    localparam int N_1B  = 6;
    localparam int N_C   = 7;
    localparam int N_D   = 8;
    localparam int N_E   = 9;
    localparam int N_F   = 10;
    localparam int N_G   = 11;
    localparam int N_A   = 12;
    localparam int N_B   = 13;
    localparam int N_C1  = 14;
    localparam int N_D1  = 15;
    localparam int N_E1  = 16;
    localparam int N_F1  = 17;
    localparam int N_G1  = 18;
    localparam int N_A1  = 19;
    localparam int N_B1  = 20;
    localparam int N_F2  = 21;
    localparam int N_G1f = 22;
    localparam int N_G1s = 23;

    typedef struct packed {
        logic [DUR_W-1:0] duration;
        logic [NOTES-1:0] note_mask;
    } song_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_GAP
    } seq_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle duration tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/music_box_sequencer.sv
// Steps through song-ROM events, holding each note mask for its duration and
// merging live keys into the registered note-bank enables.
module music_box_sequencer #(
    parameter int NOTES     = 24,
    parameter int DUR_W     = 8,
    parameter int ADDR_W    = 8,
    parameter int TICK_DIV  = 2_500_000,
    parameter int GAP_TICKS = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   loop_en,
    input  logic [NOTES-1:0]       manual_keys,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [NOTES+DUR_W-1:0] rom_data,
    output logic [NOTES-1:0]       note_mask,
    output logic                   busy,
    output logic                   song_done
);

    import music_pkg::*;

    localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_TICKS);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [NOTES-1:0]  seq_mask, seq_nxt;
    logic [DUR_W-1:0]  remaining, rem_nxt;
    logic [DUR_W-1:0]  duration;
    logic              done_nxt;
    logic              timing;
    logic              tick;

    assign duration = rom_data[NOTES +: DUR_W];
    assign timing   = (state == S_PLAY) || (state == S_GAP);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .en    (timing && !pause),
        .clr   (!timing),
        .tick  (tick)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        seq_nxt   = seq_mask;
        rem_nxt   = remaining;
        done_nxt  = 1'b0;

        if (stop) begin
            state_nxt = S_IDLE;
            seq_nxt   = '0;
            rem_nxt   = '0;
        end else if (start) begin
            state_nxt = S_FETCH;
            addr_nxt  = '0;
        end else begin
            unique case (state)
                S_IDLE:  ;
                S_FETCH: state_nxt = S_LATCH;
                S_LATCH: begin
                    if (duration == '0) begin
                        if (loop_en) begin
                            state_nxt = S_FETCH;
                            addr_nxt  = '0;
                        end else begin
                            state_nxt = S_IDLE;
                            seq_nxt   = '0;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        state_nxt = S_PLAY;
                        seq_nxt   = rom_data[NOTES-1:0];
                        rem_nxt   = duration;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        if (remaining == DUR_W'(1)) begin
                            if (GAP_TICKS > 0) begin
                                state_nxt = S_GAP;
                                seq_nxt   = '0;
                                rem_nxt   = GAP_LOAD;
                            end else begin
                                state_nxt = S_FETCH;
                                addr_nxt  = rom_addr + ADDR_W'(1);
                                rem_nxt   = '0;
                            end
                        end else begin
                            rem_nxt = remaining - DUR_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (remaining == DUR_W'(1)) begin
                            state_nxt = S_FETCH;
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            rem_nxt   = '0;
                        end else begin
                            rem_nxt = remaining - DUR_W'(1);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            seq_mask  <= '0;
            remaining <= '0;
            note_mask <= '0;
            busy      <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            seq_mask  <= seq_nxt;
            remaining <= rem_nxt;
            note_mask <= manual_keys | (pause ? '0 : seq_mask);
            busy      <= (state_nxt != S_IDLE);
            song_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_music_box_sequencer.sv
// Directed bench for music_box_sequencer with TICK_DIV = 4 and GAP_TICKS = 1;
// expected waveforms are hand-derived cycle offsets from the start edge.
module tb_music_box_sequencer;

    import music_pkg::*;

    localparam int ADDR_W = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start, stop, pause, loop_en;
    logic [NOTES-1:0]       manual_keys;
    logic [ADDR_W-1:0]      rom_addr;
    logic [NOTES+DUR_W-1:0] rom_data;
    logic [NOTES-1:0]       note_mask;
    logic                   busy, song_done;
    logic [NOTES+DUR_W-1:0] rom [2**ADDR_W];

    int checks = 0;
    int errors = 0;

    music_box_sequencer #(
        .NOTES(NOTES), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .TICK_DIV(4), .GAP_TICKS(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .manual_keys (manual_keys),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note_mask   (note_mask),
        .busy        (busy),
        .song_done   (song_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    function automatic song_entry_t entry(input int d, input logic [NOTES-1:0] m);
        entry.duration  = DUR_W'(d);
        entry.note_mask = m;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns one time unit after the edge that sampled start (offset n = 0).
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (note_mask !== '0) begin errors++; $display("FAIL reset_note got %h want 0", note_mask); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", song_done); end
        reset = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
    endtask

    task automatic test_basic_play();
        logic [NOTES-1:0] exp_note;
        pulse_start();
        for (int n = 0; n <= 30; n++) begin
            exp_note = '0;
            if (n >= 3 && n <= 10) exp_note = 24'h000080;
            if (n >= 17 && n <= 20) exp_note = 24'h000100;
            checks++; if (note_mask !== exp_note) begin errors++; $display("FAIL basic_note n=%0d got %h want %h", n, note_mask, exp_note); end
            checks++; if (busy !== (n < 26)) begin errors++; $display("FAIL basic_busy n=%0d got %b want %b", n, busy, n < 26); end
            checks++; if (song_done !== (n == 26)) begin errors++; $display("FAIL basic_done n=%0d got %b want %b", n, song_done, n == 26); end
            if (n == 0 || n == 14 || n == 24) begin
                checks++;
                if (rom_addr !== ADDR_W'(n / 10)) begin
                    errors++; $display("FAIL basic_addr n=%0d got %0d want %0d", n, rom_addr, n / 10);
                end
            end
            step();
        end
    endtask

    task automatic test_loop();
        int done_count = 0;
        loop_en = 1'b1;
        pulse_start();
        for (int n = 0; n <= 60; n++) begin
            if (song_done === 1'b1) done_count++;
            if (n == 3 || n == 29 || n == 55) begin
                checks++; if (note_mask !== 24'h000080) begin errors++; $display("FAIL loop_note n=%0d got %h want 000080", n, note_mask); end
            end
            if (n == 28 || n == 54) begin
                checks++; if (note_mask !== '0) begin errors++; $display("FAIL loop_gap n=%0d got %h want 0", n, note_mask); end
            end
            step();
        end
        checks++; if (done_count !== 0) begin errors++; $display("FAIL loop_done got %0d pulses want 0", done_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %b want 1", busy); end
        loop_en = 1'b0;
        pulse_stop();
    endtask

    task automatic test_pause();
        pulse_start();
        for (int n = 0; n <= 40; n++) begin
            if (n == 6 || n == 10 || n == 15 || n == 21) begin
                checks++; if (note_mask !== '0) begin errors++; $display("FAIL pause_mute n=%0d got %h want 0", n, note_mask); end
            end
            if (n == 16 || n == 20) begin
                checks++; if (note_mask !== 24'h000080) begin errors++; $display("FAIL pause_resume n=%0d got %h want 000080", n, note_mask); end
            end
            if (n == 35 || n == 36) begin
                checks++; if (song_done !== (n == 36)) begin errors++; $display("FAIL pause_done n=%0d got %b want %b", n, song_done, n == 36); end
                checks++; if (busy !== (n == 35)) begin errors++; $display("FAIL pause_busy n=%0d got %b want %b", n, busy, n == 35); end
            end
            if (n == 5) pause = 1'b1;
            if (n == 15) pause = 1'b0;
            step();
        end
    endtask

    task automatic test_manual_merge();
        pulse_start();
        for (int n = 0; n <= 30; n++) begin
            if (n == 5 || n == 8) begin
                checks++; if (note_mask !== 24'h800080) begin errors++; $display("FAIL merge_play n=%0d got %h want 800080", n, note_mask); end
            end
            if (n == 11) begin
                checks++; if (note_mask !== 24'h800000) begin errors++; $display("FAIL merge_gap got %h want 800000", note_mask); end
            end
            if (n == 4) manual_keys = 24'h800000;
            step();
        end
        manual_keys = '0;
        step();
        checks++; if (note_mask !== '0) begin errors++; $display("FAIL merge_idle_off got %h want 0", note_mask); end
        manual_keys = 24'h800000;
        #1;
        checks++; if (note_mask !== '0) begin errors++; $display("FAIL merge_latency got %h want 0", note_mask); end
        step();
        checks++; if (note_mask !== 24'h800000) begin errors++; $display("FAIL merge_idle got %h want 800000", note_mask); end
        manual_keys = '0;
        step();
    endtask

    task automatic test_stop_start();
        pulse_start();
        repeat (5) step();
        stop = 1'b1; start = 1'b1; manual_keys = 24'h000001;
        step();
        stop = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_busy got %b want 0", busy); end
        for (int n = 0; n < 4; n++) begin
            checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL collide_done n=%0d got %b want 0", n, song_done); end
            step();
        end
        checks++; if (note_mask !== 24'h000001) begin errors++; $display("FAIL collide_note got %h want 000001", note_mask); end
        manual_keys = '0;
        pulse_start();
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL restart_addr got %0d want 0", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
        repeat (3) step();
        checks++; if (note_mask !== 24'h000080) begin errors++; $display("FAIL restart_note got %h want 000080", note_mask); end
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        repeat (18) step();
        checks++; if (rom_addr !== ADDR_W'(1)) begin errors++; $display("FAIL b2b_addr1 got %0d want 1", rom_addr); end
        checks++; if (note_mask !== 24'h000100) begin errors++; $display("FAIL b2b_note1 got %h want 000100", note_mask); end
        pulse_start();
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL b2b_addr0 got %0d want 0", rom_addr); end
        step(); step();
        checks++; if (note_mask !== 24'h000100) begin errors++; $display("FAIL b2b_tie got %h want 000100", note_mask); end
        step();
        checks++; if (note_mask !== 24'h000080) begin errors++; $display("FAIL b2b_first got %h want 000080", note_mask); end
        pulse_stop();
    endtask

    task automatic test_reset_mid_song();
        pulse_start();
        repeat (18) step();
        #2 reset = 1'b0;
        #1;
        checks++; if (note_mask !== '0) begin errors++; $display("FAIL arst_note got %h want 0", note_mask); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL arst_addr got %0d want 0", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        #3 reset = 1'b1;
        repeat (6) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_stay_idle got %b want 0", busy); end
        checks++; if (note_mask !== '0) begin errors++; $display("FAIL arst_stay_note got %h want 0", note_mask); end
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_restart got %b want 1", busy); end
        pulse_stop();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        manual_keys = '0;
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = '0;
        rom[0] = entry(2, NOTES'(1) << N_C);
        rom[1] = entry(1, NOTES'(1) << N_D);

        test_reset();
        test_basic_play();
        test_loop();
        test_pause();
        test_manual_merge();
        test_stop_start();
        test_back_to_back();
        test_reset_mid_song();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
